circuit5_hlsm: RTL
==================

CIRCUIT5_HLSM -- requirements
Module: circuit5_hlsm

Interface
REQ-001 Parameter: DATAWIDTH, default 64, width of operands a/b/c and all internal datapath registers.
REQ-002 Parameter: OUTWIDTH, default 32, width of outputs x/z (low OUTWIDTH bits of the results).
REQ-003 Port: Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: Rst  input  1  reset, synchronous, active-high.
REQ-005 Port: Start  input  1  begin operation; sampled only in state WAIT.
REQ-006 Port: a, b, c  input  DATAWIDTH each  operands, unsigned, latched when Start is accepted.
REQ-007 Port: Busy  output  1  high in every state except WAIT; registered.
REQ-008 Port: Done  output  1  one-cycle completion pulse; registered.
REQ-009 Port: x, z  output  OUTWIDTH each  results; registered; hold value between operations.

Function
REQ-010 The block SHALL compute with an internal register per intermediate, mod 2^DATAWIDTH:
- d=a+b, e=a+c, f=a-b
- dLTe=(d<e) unsigned, dEQe=(d==e)
- g=dLTe?d:e, h=dEQe?g:f
- x=(h<<dLTe)[OUTWIDTH-1:0], z=(g>>dEQe)[OUTWIDTH-1:0] (logical shift)
REQ-011 FSM states SHALL be WAIT, ADD_D, ADD_E, SUB_F, CMP, SEL, SHIFT, DONE.
REQ-012 WAIT: Start=1 at edge k SHALL latch a,b,c and go to ADD_D; Start=0 stays in WAIT.
REQ-013 Default build SHALL use one shared add/sub unit.
- ADD_D registers d; ADD_E registers e; SUB_F registers f, one state each, in that order.
REQ-014 CMP SHALL register dLTe/dEQe; SEL SHALL register g,h; SHIFT SHALL register x,z and go to DONE.
REQ-015 DONE SHALL drive Done=1 for exactly one cycle, then go unconditionally to WAIT.
REQ-016 Latency (default): Start sampled at edge k -> x,z and Done=1 valid in the cycle after edge k+6.
REQ-017 Start SHALL be ignored in every state other than WAIT, including DONE; no queuing.
REQ-018 Back-to-back: Start held high SHALL begin a new operation at the first edge in WAIT after DONE.
REQ-019 Changes on a/b/c after acceptance SHALL NOT affect the operation in flight.
REQ-020 Overflow/underflow SHALL wrap silently; no status flag.
REQ-021 Shifted-out bits SHALL be discarded; truncation to OUTWIDTH SHALL take the low bits.

Reset
REQ-022 Rst=1 at an edge SHALL force state WAIT, Busy=0, Done=0, x=0, z=0, and clear all intermediates and flags to 0.
REQ-023 Rst SHALL take priority over Start and over any state transition.
REQ-024 Rst mid-operation SHALL abort the operation; no Done pulse for it.

Configuration
REQ-025 Macro C5_PARALLEL_ALU_EN undefined: single shared add/sub unit; latency per REQ-016.
REQ-026 Macro C5_PARALLEL_ALU_EN defined:
- three adders/subtractors compute d,e,f together in ADD_D
- ADD_D goes directly to CMP; ADD_E and SUB_F are unreachable
- Done=1 in the cycle after edge k+4
- results identical to the default build.

Verification
REQ-027 a=10,b=5,c=3, Start pulse -> after latency x=5, z=13, Done high exactly one cycle.
REQ-028 a=8,b=4,c=4 (d==e) -> x=12, z=6.
REQ-029 a=1,b=2,c=7 (d<e, f wraps) -> x=0xFFFFFFFE, z=3.
REQ-030 a=0xFFFFFFFFFFFFFFFF,b=1,c=2 (d wraps to 0) -> x=0xFFFFFFFC, z=0.
REQ-031 Start pulsed again in ADD_E with new operands -> ignored; first result unchanged; one Done pulse.
REQ-032 Rst asserted in CMP -> next cycle WAIT, Busy=0, x=z=0, no Done; a following Start completes normally.
- Run REQ-027 to REQ-032 with and without C5_PARALLEL_ALU_EN.

Source files
------------

// File: rtl/circuit5_hlsm_if.sv
// rtl/circuit5_hlsm_if.sv - start/operand/result bundle for circuit5_hlsm
//
// Carries everything except clock and reset between a requester and
// circuit5_hlsm.
//   Start    requester -> block   begin an operation (honoured only when idle)
//   a, b, c  requester -> block   unsigned operands, DATAWIDTH bits each
//   Busy     block -> requester   high whenever an operation is in progress
//   Done     block -> requester   one-cycle completion pulse
//   x, z     block -> requester   OUTWIDTH-bit results, held between operations
//
// The master modport is the requester side; the slave modport is the block.

interface circuit5_hlsm_if #(
  parameter int DATAWIDTH = 64,
  parameter int OUTWIDTH  = 32
);

  logic                 Start;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic [DATAWIDTH-1:0] c;
  logic                 Busy;
  logic                 Done;
  logic [OUTWIDTH-1:0]  x;
  logic [OUTWIDTH-1:0]  z;

  modport master (
    output Start,
    output a,
    output b,
    output c,
    input  Busy,
    input  Done,
    input  x,
    input  z
  );

  modport slave (
    input  Start,
    input  a,
    input  b,
    input  c,
    output Busy,
    output Done,
    output x,
    output z
  );

endinterface

// File: rtl/circuit5_hlsm.sv
// rtl/circuit5_hlsm.sv - multi-cycle add/compare/select/shift datapath with start/done control
//
// Computes, modulo 2^DATAWIDTH on latched operands a, b, c:
//   d = a + b, e = a + c, f = a - b
//   dLTe = (d < e), dEQe = (d == e)
//   g = dLTe ? d : e, h = dEQe ? g : f
//   x = low OUTWIDTH bits of (h << dLTe), z = low OUTWIDTH bits of (g >> dEQe)
//
// Ports:
//   Clk  input   single clock, rising edge
//   Rst  input   synchronous active-high reset
//   bus  slave   circuit5_hlsm_if: Start, a, b, c in; Busy, Done, x, z out
//
// Build option:
//   C5_PARALLEL_ALU_EN  undefined: one shared add/sub unit produces d, e, f in
//                       three consecutive states (Done in the cycle after the
//                       6th edge following the accepting edge).
//                       defined: three add/sub units produce d, e, f together
//                       in ADD_D, which goes straight to CMP (Done in the
//                       cycle after the 4th edge). Results are identical.
//
// Parameters: DATAWIDTH (operand/intermediate width), OUTWIDTH (result
// width, expected <= DATAWIDTH). Interface parameters must match.

module circuit5_hlsm #(
  parameter int DATAWIDTH = 64,
  parameter int OUTWIDTH  = 32
) (
  input  logic           Clk,
  input  logic           Rst,
  circuit5_hlsm_if.slave bus
);

  // State encoding kept as plain constants so the codes stay stable for
  // anything that decodes them externally (debug probes, older benches).
  localparam logic [2:0] ST_WAIT  = 3'd0;
  localparam logic [2:0] ST_ADD_D = 3'd1;
  localparam logic [2:0] ST_ADD_E = 3'd2;
  localparam logic [2:0] ST_SUB_F = 3'd3;
  localparam logic [2:0] ST_CMP   = 3'd4;
  localparam logic [2:0] ST_SEL   = 3'd5;
  localparam logic [2:0] ST_SHIFT = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  logic [2:0]           state;
  logic [2:0]           state_nxt;

  // Operand latches: the operation in flight never looks at bus.a/b/c again.
  logic [DATAWIDTH-1:0] a_r;
  logic [DATAWIDTH-1:0] b_r;
  logic [DATAWIDTH-1:0] c_r;

  // Intermediates, one register each.
  logic [DATAWIDTH-1:0] d;
  logic [DATAWIDTH-1:0] e;
  logic [DATAWIDTH-1:0] f;
  logic                 dlte;
  logic                 deqe;
  logic [DATAWIDTH-1:0] g;
  logic [DATAWIDTH-1:0] h;

  // Output registers.
  logic                 busy_r;
  logic                 done_r;
  logic [OUTWIDTH-1:0]  x_r;
  logic [OUTWIDTH-1:0]  z_r;

  // Full-width shifted values; only the low OUTWIDTH bits are kept, so bits
  // shifted past the top of h and the upper bits of both are discarded.
  logic [DATAWIDTH-1:0] h_shl;
  logic [DATAWIDTH-1:0] g_shr;

  assign bus.Busy = busy_r;
  assign bus.Done = done_r;
  assign bus.x    = x_r;
  assign bus.z    = z_r;

  // ---------------------------------------------------------------------
  // Arithmetic resources
  // ---------------------------------------------------------------------
`ifdef C5_PARALLEL_ALU_EN
  logic [DATAWIDTH-1:0] sum_ab;
  logic [DATAWIDTH-1:0] sum_ac;
  logic [DATAWIDTH-1:0] dif_ab;

  always_comb begin
    sum_ab = a_r + b_r;
    sum_ac = a_r + c_r;
    dif_ab = a_r - b_r;
  end
`else
  // Single adder reused for all three results. Subtraction is done as
  // a + ~b + 1, so the operand mux and carry-in are the only extra logic.
  logic                 alu_sub;
  logic [DATAWIDTH-1:0] alu_b;
  logic [DATAWIDTH-1:0] alu_y;

  always_comb begin
    alu_sub = (state == ST_SUB_F);
    alu_b   = (state == ST_ADD_E) ? c_r : b_r;
    alu_y   = a_r + (alu_sub ? ~alu_b : alu_b)
                  + {{(DATAWIDTH-1){1'b0}}, alu_sub};
  end
`endif

  always_comb begin
    h_shl = dlte ? {h[DATAWIDTH-2:0], 1'b0} : h;
    g_shr = deqe ? {1'b0, g[DATAWIDTH-1:1]} : g;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT:  state_nxt = bus.Start ? ST_ADD_D : ST_WAIT;
`ifdef C5_PARALLEL_ALU_EN
      ST_ADD_D: state_nxt = ST_CMP;
`else
      ST_ADD_D: state_nxt = ST_ADD_E;
`endif
      // ADD_E and SUB_F are unreachable in the parallel build; their arcs
      // are kept so a corrupted state still drains back to WAIT.
      ST_ADD_E: state_nxt = ST_SUB_F;
      ST_SUB_F: state_nxt = ST_CMP;
      ST_CMP:   state_nxt = ST_SEL;
      ST_SEL:   state_nxt = ST_SHIFT;
      ST_SHIFT: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_WAIT;
      default:  state_nxt = ST_WAIT;
    endcase
  end

  // ---------------------------------------------------------------------
  // State, datapath and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= ST_WAIT;
      a_r    <= '0;
      b_r    <= '0;
      c_r    <= '0;
      d      <= '0;
      e      <= '0;
      f      <= '0;
      dlte   <= 1'b0;
      deqe   <= 1'b0;
      g      <= '0;
      h      <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      x_r    <= '0;
      z_r    <= '0;
    end else begin
      state  <= state_nxt;
      // Busy/Done are decoded from the state being entered so they line up
      // with the state register instead of lagging it by a cycle.
      busy_r <= (state_nxt != ST_WAIT);
      done_r <= (state_nxt == ST_DONE);

      case (state)
        ST_WAIT: begin
          if (bus.Start) begin
            a_r <= bus.a;
            b_r <= bus.b;
            c_r <= bus.c;
          end
        end
`ifdef C5_PARALLEL_ALU_EN
        ST_ADD_D: begin
          d <= sum_ab;
          e <= sum_ac;
          f <= dif_ab;
        end
`else
        ST_ADD_D: d <= alu_y;
        ST_ADD_E: e <= alu_y;
        ST_SUB_F: f <= alu_y;
`endif
        ST_CMP: begin
          dlte <= (d < e);
          deqe <= (d == e);
        end
        ST_SEL: begin
          // h takes the value g is being loaded with, not g's old contents.
          g <= dlte ? d : e;
          if (deqe) begin
            h <= dlte ? d : e;
          end else begin
            h <= f;
          end
        end
        ST_SHIFT: begin
          x_r <= h_shl[OUTWIDTH-1:0];
          z_r <= g_shr[OUTWIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
